// File: rtl/bsg_fifo_banked_pkg.sv
// Sizing helpers shared by the banked round-robin FIFO and its per-bank storage.
package bsg_fifo_banked_pkg;

  // Width of an index that can take n distinct values; never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned bank_depth(input int unsigned els, input int unsigned banks);
    return els / banks;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return idx_width(depth);
  endfunction

  function automatic int unsigned bank_sel_width(input int unsigned banks);
    return idx_width(banks);
  endfunction

  function automatic int unsigned count_width(input int unsigned els);
    return $clog2(els + 1);
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_bank.sv
// Single register-array FIFO bank: head/tail pointers plus an occupancy counter.
module bsg_fifo_1r1w_bank
  import bsg_fifo_banked_pkg::*;
#(
  parameter int unsigned width_p = 8,
  parameter int unsigned depth_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int unsigned PW = ptr_width(depth_p);
  localparam int unsigned CW = count_width(depth_p);

  logic [width_p-1:0] mem_q [depth_p];
  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               enq, deq;

  assign ready_o = (cnt_q != CW'(depth_p));
  assign v_o     = (cnt_q != '0);
  assign data_o  = mem_q[head_q];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  // Pointer/occupancy next state; clear overrides any same-cycle transfer.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (enq) tail_d = (tail_q == PW'(depth_p - 1)) ? '0 : tail_q + PW'(1);
      if (deq) head_d = (head_q == PW'(depth_p - 1)) ? '0 : head_q + PW'(1);
      case ({enq, deq})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is deliberately not reset; pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (enq && !clear_i) mem_q[tail_q] <= data_i;
  end

endmodule

// File: rtl/bsg_fifo_1r1w_banked_rr.sv
// Deep 1r1w FIFO striped round-robin across equal-depth banks; strict FIFO order.
module bsg_fifo_1r1w_banked_rr
  import bsg_fifo_banked_pkg::*;
#(
  parameter int unsigned width_p              = 128,
  parameter int unsigned els_p                = 512,
  parameter int unsigned num_banks_p          = 4,
  parameter int unsigned almost_full_thresh_p = els_p - 4
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            clear_i,
  input  logic [width_p-1:0]              data_i,
  input  logic                            v_i,
  output logic                            ready_o,
  output logic                            v_o,
  output logic [width_p-1:0]              data_o,
  input  logic                            yumi_i,
  output logic [count_width(els_p)-1:0]   count_o,
  output logic                            almost_full_o
);

  localparam int unsigned DEPTH = bank_depth(els_p, num_banks_p);
  localparam int unsigned BW    = bank_sel_width(num_banks_p);
  localparam int unsigned CW    = count_width(els_p);

  logic [BW-1:0]        wr_bank_q, wr_bank_d;
  logic [BW-1:0]        rd_bank_q, rd_bank_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 enq, deq;

  logic [num_banks_p-1:0] bank_ready, bank_v, bank_enq, bank_deq;
  logic [width_p-1:0]     bank_data [num_banks_p];

  assign enq = v_i & ready_o;
  assign deq = yumi_i & v_o;

  for (genvar b = 0; b < num_banks_p; b++) begin : g_bank
    assign bank_enq[b] = enq && (wr_bank_q == BW'(b));
    assign bank_deq[b] = deq && (rd_bank_q == BW'(b));

    bsg_fifo_1r1w_bank #(
      .width_p (width_p),
      .depth_p (DEPTH)
    ) u_bank (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .clear_i   (clear_i),
      .v_i       (bank_enq[b]),
      .data_i    (data_i),
      .ready_o   (bank_ready[b]),
      .v_o       (bank_v[b]),
      .data_o    (bank_data[b]),
      .yumi_i    (bank_deq[b])
    );
  end

  // Select the write-side and read-side bank views; loop form keeps non-power-of-2 counts in range.
  always_comb begin
    ready_o = 1'b0;
    v_o     = 1'b0;
    data_o  = '0;
    for (int unsigned b = 0; b < num_banks_p; b++) begin
      if (wr_bank_q == BW'(b)) ready_o = bank_ready[b];
      if (rd_bank_q == BW'(b)) begin
        v_o    = bank_v[b];
        data_o = bank_data[b];
      end
    end
  end

  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    count_d   = count_q;
    if (clear_i) begin
      wr_bank_d = '0;
      rd_bank_d = '0;
      count_d   = '0;
    end else begin
      if (enq) wr_bank_d = (wr_bank_q == BW'(num_banks_p - 1)) ? '0 : wr_bank_q + BW'(1);
      if (deq) rd_bank_d = (rd_bank_q == BW'(num_banks_p - 1)) ? '0 : rd_bank_q + BW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_bank_q <= '0;
      rd_bank_q <= '0;
      count_q   <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      count_q   <= count_d;
    end
  end

  assign count_o       = count_q;
  assign almost_full_o = (count_q >= CW'(almost_full_thresh_p));

  yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
  count_range: assert property (@(posedge clk_i) disable iff (!reset_n_i) count_q <= CW'(els_p));

endmodule

// File: tb/tb_bsg_fifo_1r1w_banked_rr.sv
// Directed bench for the banked round-robin FIFO: 8x2 table sequence plus a 9x3 scoreboard run.
module tb_bsg_fifo_1r1w_banked_rr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 8 entries, 2 banks, almost-full at 6
  logic       a_clr, a_v, a_rdy, a_vo, a_y, a_af;
  logic [7:0] a_d, a_do;
  logic [3:0] a_cnt;

  bsg_fifo_1r1w_banked_rr #(.width_p(8), .els_p(8), .num_banks_p(2), .almost_full_thresh_p(6)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .clear_i(a_clr), .data_i(a_d), .v_i(a_v), .ready_o(a_rdy),
    .v_o(a_vo), .data_o(a_do), .yumi_i(a_y), .count_o(a_cnt), .almost_full_o(a_af));

  // Instance B: 9 entries, 3 banks, default threshold (5)
  logic       b_clr, b_v, b_rdy, b_vo, b_y, b_af;
  logic [7:0] b_d, b_do;
  logic [3:0] b_cnt;

  bsg_fifo_1r1w_banked_rr #(.width_p(8), .els_p(9), .num_banks_p(3)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .clear_i(b_clr), .data_i(b_d), .v_i(b_v), .ready_o(b_rdy),
    .v_o(b_vo), .data_o(b_do), .yumi_i(b_y), .count_o(b_cnt), .almost_full_o(b_af));

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  typedef struct {
    logic v; logic [7:0] d; logic y; logic c;
    logic e_rdy; logic e_v; logic chk_d; logic [7:0] e_d; logic [3:0] e_cnt; logic e_af;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic y, input logic c,
                              input logic e_rdy, input logic e_v, input logic chk_d,
                              input logic [7:0] e_d, input logic [3:0] e_cnt, input logic e_af);
    vec_t r;
    r.v = v; r.d = d; r.y = y; r.c = c;
    r.e_rdy = e_rdy; r.e_v = e_v; r.chk_d = chk_d; r.e_d = e_d; r.e_cnt = e_cnt; r.e_af = e_af;
    return r;
  endfunction

  logic [7:0] q[$];
  int pushed;
  int cyc;
  logic do_push, do_pop;

  initial begin
    // Fill 0x01..0x08; ready drops at 8, almost-full rises at 6
    vecs[0]  = mk(1, 8'h01, 0, 0, 1, 0, 0, 8'h00, 4'd0, 0);
    vecs[1]  = mk(1, 8'h02, 0, 0, 1, 1, 1, 8'h01, 4'd1, 0);
    vecs[2]  = mk(1, 8'h03, 0, 0, 1, 1, 1, 8'h01, 4'd2, 0);
    vecs[3]  = mk(1, 8'h04, 0, 0, 1, 1, 1, 8'h01, 4'd3, 0);
    vecs[4]  = mk(1, 8'h05, 0, 0, 1, 1, 1, 8'h01, 4'd4, 0);
    vecs[5]  = mk(1, 8'h06, 0, 0, 1, 1, 1, 8'h01, 4'd5, 0);
    vecs[6]  = mk(1, 8'h07, 0, 0, 1, 1, 1, 8'h01, 4'd6, 1);
    vecs[7]  = mk(1, 8'h08, 0, 0, 1, 1, 1, 8'h01, 4'd7, 1);
    // Full: push blocked while the pop frees a slot, then steady enq+deq at 7
    vecs[8]  = mk(0, 8'h00, 0, 0, 0, 1, 1, 8'h01, 4'd8, 1);
    vecs[9]  = mk(1, 8'h10, 1, 0, 0, 1, 1, 8'h01, 4'd8, 1);
    vecs[10] = mk(1, 8'h10, 1, 0, 1, 1, 1, 8'h02, 4'd7, 1);
    vecs[11] = mk(1, 8'h11, 1, 0, 1, 1, 1, 8'h03, 4'd7, 1);
    vecs[12] = mk(1, 8'h12, 1, 0, 1, 1, 1, 8'h04, 4'd7, 1);
    vecs[13] = mk(1, 8'h13, 1, 0, 1, 1, 1, 8'h05, 4'd7, 1);
    vecs[14] = mk(1, 8'h14, 1, 0, 1, 1, 1, 8'h06, 4'd7, 1);
    vecs[15] = mk(1, 8'h15, 1, 0, 1, 1, 1, 8'h07, 4'd7, 1);
    vecs[16] = mk(1, 8'h16, 1, 0, 1, 1, 1, 8'h08, 4'd7, 1);
    vecs[17] = mk(1, 8'h17, 1, 0, 1, 1, 1, 8'h10, 4'd7, 1);
    // Drain to 5: almost-full clears one pop below threshold
    vecs[18] = mk(0, 8'h00, 1, 0, 1, 1, 1, 8'h11, 4'd7, 1);
    vecs[19] = mk(0, 8'h00, 1, 0, 1, 1, 1, 8'h12, 4'd6, 1);
    vecs[20] = mk(0, 8'h00, 0, 0, 1, 1, 1, 8'h13, 4'd5, 0);
    // Clear with enq+deq in the same cycle, then single push/pop of 0xAA
    vecs[21] = mk(1, 8'h55, 1, 1, 1, 1, 1, 8'h13, 4'd5, 0);
    vecs[22] = mk(1, 8'hAA, 0, 0, 1, 0, 0, 8'h00, 4'd0, 0);
    vecs[23] = mk(0, 8'h00, 1, 0, 1, 1, 1, 8'hAA, 4'd1, 0);
    vecs[24] = mk(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 4'd0, 0);

    a_clr = 0; a_v = 0; a_d = '0; a_y = 0;
    b_clr = 0; b_v = 0; b_d = '0; b_y = 0;
    repeat (3) @(negedge clk);
    chk("reset_count", 32'(a_cnt), 32'd0);
    chk("reset_v", 32'(a_vo), 32'd0);
    chk("reset_ready", 32'(a_rdy), 32'd1);
    chk("reset_af", 32'(a_af), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      a_v = vecs[i].v; a_d = vecs[i].d; a_y = vecs[i].y; a_clr = vecs[i].c;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(a_rdy), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_v", i), 32'(a_vo), 32'(vecs[i].e_v));
      chk($sformatf("vec%0d_count", i), 32'(a_cnt), 32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_af", i), 32'(a_af), 32'(vecs[i].e_af));
      if (vecs[i].chk_d) chk($sformatf("vec%0d_data", i), 32'(a_do), 32'(vecs[i].e_d));
    end
    @(negedge clk);
    a_v = 0; a_y = 0; a_clr = 0;

    // Three-bank scoreboard run with throttled push/pop on both sides
    pushed = 0;
    cyc = 0;
    while (!(pushed == 20 && q.size() == 0) && cyc < 400) begin
      @(negedge clk);
      chk("sb_ready", 32'(b_rdy), 32'(q.size() != 9));
      chk("sb_v", 32'(b_vo), 32'(q.size() != 0));
      chk("sb_count", 32'(b_cnt), 32'(q.size()));
      chk("sb_af", 32'(b_af), 32'(q.size() >= 5));
      if (q.size() != 0) chk("sb_data", 32'(b_do), 32'(q[0]));
      do_push = ($urandom_range(0, 1) == 1) && pushed < 20 && q.size() != 9;
      do_pop  = ($urandom_range(0, 1) == 1) && q.size() != 0;
      b_v = do_push;
      b_d = 8'(8'h30 + pushed);
      b_y = do_pop;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(8'(8'h30 + pushed));
        pushed++;
      end
      cyc++;
    end
    chk("sb_completed", 32'(pushed == 20 && q.size() == 0), 32'd1);
    @(negedge clk);
    b_v = 0; b_y = 0;

    // Async reset mid-burst between edges
    a_v = 1; a_d = 8'h61;
    @(negedge clk); a_d = 8'h62;
    @(negedge clk); a_d = 8'h63;
    @(negedge clk); a_d = 8'h64;
    chk("burst_count", 32'(a_cnt), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_now_count", 32'(a_cnt), 32'd0);
    chk("rst_now_v", 32'(a_vo), 32'd0);
    chk("rst_now_ready", 32'(a_rdy), 32'd1);
    @(negedge clk);
    a_v = 0;
    chk("rst_hold_count", 32'(a_cnt), 32'd0);
    rst_n = 1'b1;
    chk("rst_wr_bank", 32'(dut_a.wr_bank_q), 32'd0);
    a_v = 1; a_d = 8'h77;
    @(negedge clk); a_d = 8'h78;
    @(negedge clk); a_v = 0;
    #1;
    chk("resume_count", 32'(a_cnt), 32'd2);
    chk("resume_head", 32'(a_do), 32'h77);
    a_y = 1;
    @(negedge clk); a_y = 0;
    #1;
    chk("resume_second", 32'(a_do), 32'h78);
    chk("resume_count1", 32'(a_cnt), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
